univ_shift_reg: RTL and testbench

Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with true and complemented outputs. Adds a clock enable, eight operating modes (hold, shift, rotate, parallel load, clear, set), serial in/out on both ends, and a shift counter with a completion pulse. It serves as the common storage and serialiser element for later assignments (SIPO/PISO, LED chasers, UART framing).

---
 rtl/eld_pkg.sv | 14 +
 rtl/univ_shift_reg_sat_counter.sv | 34 +++
 rtl/univ_shift_reg.sv | 102 ++++++++++
 tb/tb_univ_shift_reg.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/eld_pkg.sv
// Shared constants for the lab storage elements.
// The mode encoding is common to every block that drives a univ_shift_reg.
package eld_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHR  = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_ROR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_LOAD = 3'b101;
   localparam logic [2:0] MODE_CLR  = 3'b110;
   localparam logic [2:0] MODE_SET  = 3'b111;

endpackage

// File: rtl/univ_shift_reg_sat_counter.sv
// Saturating up-counter with a registered one-shot pulse on reaching MAX.
// Once saturated, further increments are ignored until clr or reset.
module sat_counter #(
   parameter int CNT_W = 4,
   parameter int MAX   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             hit_pulse
);

   localparam logic [CNT_W-1:0] MAX_V      = CNT_W'(MAX);
   localparam logic [CNT_W-1:0] MAX_MINUS1 = CNT_W'(MAX - 1);

   // The pulse fires only on the step into MAX, so holding at MAX cannot re-arm it.
   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= '0;
         hit_pulse <= 1'b0;
      end else begin
         hit_pulse <= 1'b0;
         if (clr) begin
            count <= '0;
         end else if (inc && (count != MAX_V)) begin
            count     <= count + 1'b1;
            hit_pulse <= (count == MAX_MINUS1);
         end
      end
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold, shift, rotate, load, clear, set,
// with serial ports at both ends and a saturating shift counter.
module univ_shift_reg
   import eld_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic [2:0]                   mode,
   input  logic [WIDTH-1:0]             in_D,
   input  logic                         ser_in_r,
   input  logic                         ser_in_l,
   output logic [WIDTH-1:0]             out_Q,
   output logic [WIDTH-1:0]             out_QBar,
   output logic                         ser_out_r,
   output logic                         ser_out_l,
   output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
   output logic                         cnt_done
);

   localparam int CNT_W = $clog2(WIDTH+1);

   logic [WIDTH-1:0] next_q;
   logic             is_shift;
   logic             is_reload;

   // Widened views let the same slicing serve WIDTH=1, where a rotate degenerates to hold.
   logic [WIDTH:0]   shr_ext;
   logic [WIDTH:0]   shl_ext;
   logic [WIDTH:0]   ror_ext;
   logic [WIDTH:0]   rol_ext;

   assign shr_ext = {ser_in_r, out_Q};
   assign shl_ext = {out_Q, ser_in_l};
   assign ror_ext = {out_Q[0], out_Q};
   assign rol_ext = {out_Q, out_Q[WIDTH-1]};

   always_comb begin
      next_q    = out_Q;
      is_shift  = 1'b0;
      is_reload = 1'b0;
      case (mode)
         MODE_SHR: begin
            next_q   = shr_ext[WIDTH:1];
            is_shift = 1'b1;
         end
         MODE_SHL: begin
            next_q   = shl_ext[WIDTH-1:0];
            is_shift = 1'b1;
         end
         MODE_ROR: begin
            next_q   = ror_ext[WIDTH:1];
            is_shift = 1'b1;
         end
         MODE_ROL: begin
            next_q   = rol_ext[WIDTH-1:0];
            is_shift = 1'b1;
         end
         MODE_LOAD: begin
            next_q    = in_D;
            is_reload = 1'b1;
         end
         MODE_CLR: begin
            next_q    = '0;
            is_reload = 1'b1;
         end
         MODE_SET: begin
            next_q    = '1;
            is_reload = 1'b1;
         end
         default: next_q = out_Q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_Q <= RESET_VAL;
      end else if (en) begin
         out_Q <= next_q;
      end
   end

   assign out_QBar  = ~out_Q;
   assign ser_out_r = out_Q[0];
   assign ser_out_l = out_Q[WIDTH-1];

   sat_counter #(
      .CNT_W (CNT_W),
      .MAX   (WIDTH)
   ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .clr       (en && is_reload),
      .inc       (en && is_shift),
      .count     (shift_cnt),
      .hit_pulse (cnt_done)
   );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: an 8-bit and a 1-bit instance share stimulus and are
// checked every cycle against an arithmetic model, plus hand-computed checkpoints.
module tb_univ_shift_reg;
   import eld_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic [2:0] mode = MODE_HOLD;
   logic [7:0] in_d8 = '0;
   logic [0:0] in_d1 = '0;
   logic       ser_in_r = 1'b0;
   logic       ser_in_l = 1'b0;

   logic [7:0] q8, qb8;
   logic       sor8, sol8, done8;
   logic [3:0] cnt8;
   logic [0:0] q1, qb1;
   logic       sor1, sol1, done1;
   logic [0:0] cnt1;

   int n_checks = 0;
   int n_miss   = 0;

   always #5 clk = ~clk;

   univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h3C)) dut8 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .in_D(in_d8),
      .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .out_Q(q8), .out_QBar(qb8),
      .ser_out_r(sor8), .ser_out_l(sol8), .shift_cnt(cnt8), .cnt_done(done8)
   );

   univ_shift_reg #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .in_D(in_d1),
      .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .out_Q(q1), .out_QBar(qb1),
      .ser_out_r(sor1), .ser_out_l(sol1), .shift_cnt(cnt1), .cnt_done(done1)
   );

   // Reference model: register value as an integer, operations as plain arithmetic.
   function automatic int model_next(int w, int q, logic [2:0] m, int d, bit sr, bit sl);
      int mask;
      mask = (1 << w) - 1;
      case (m)
         3'd1:    return (q >> 1) | (int'(sr) << (w - 1));
         3'd2:    return ((q << 1) | int'(sl)) & mask;
         3'd3:    return (q >> 1) | ((q & 1) << (w - 1));
         3'd4:    return ((q << 1) | (q >> (w - 1))) & mask;
         3'd5:    return d & mask;
         3'd6:    return 0;
         3'd7:    return mask;
         default: return q;
      endcase
   endfunction

   int m8_q, m8_cnt, m1_q, m1_cnt;
   bit m8_done, m1_done;
   bit model_valid = 1'b0;

   always @(posedge clk) begin
      bit shifting;
      bit reloading;
      shifting  = (mode >= 3'd1) && (mode <= 3'd4);
      reloading = (mode >= 3'd5);
      if (reset) begin
         m8_q <= 32'h3C; m8_cnt <= 0; m8_done <= 1'b0;
         m1_q <= 0;      m1_cnt <= 0; m1_done <= 1'b0;
         model_valid <= 1'b1;
      end else if (en) begin
         m8_q    <= model_next(8, m8_q, mode, int'(in_d8), ser_in_r, ser_in_l);
         m1_q    <= model_next(1, m1_q, mode, int'(in_d1), ser_in_r, ser_in_l);
         m8_cnt  <= reloading ? 0 : (shifting ? ((m8_cnt < 8) ? m8_cnt + 1 : 8) : m8_cnt);
         m1_cnt  <= reloading ? 0 : (shifting ? ((m1_cnt < 1) ? m1_cnt + 1 : 1) : m1_cnt);
         m8_done <= shifting && (m8_cnt == 7);
         m1_done <= shifting && (m1_cnt == 0);
      end else begin
         m8_done <= 1'b0;
         m1_done <= 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (model_valid) begin
         checkOutput("m8.q",    32'(q8),    32'(m8_q));
         checkOutput("m8.qbar", 32'(qb8),   32'(~m8_q & 8'hFF));
         checkOutput("m8.sor",  32'(sor8),  32'(m8_q & 1));
         checkOutput("m8.sol",  32'(sol8),  32'((m8_q >> 7) & 1));
         checkOutput("m8.cnt",  32'(cnt8),  32'(m8_cnt));
         checkOutput("m8.done", 32'(done8), 32'(m8_done));
         checkOutput("m1.q",    32'(q1),    32'(m1_q));
         checkOutput("m1.qbar", 32'(qb1),   32'(~m1_q & 1));
         checkOutput("m1.cnt",  32'(cnt1),  32'(m1_cnt));
         checkOutput("m1.done", 32'(done1), 32'(m1_done));
      end
   end

   // Drives one vector after the falling edge and returns at the next falling edge.
   task automatic applyStimulus(input bit r, input bit e, input logic [2:0] m,
                                input logic [7:0] d, input bit sr, input bit sl);
      reset    = r;
      en       = e;
      mode     = m;
      in_d8    = d;
      in_d1    = d[0];
      ser_in_r = sr;
      ser_in_l = sl;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);

      // Reset, then parallel load
      applyStimulus(1, 0, MODE_HOLD, 8'h00, 0, 0);
      checkOutput("rst.q",    32'(q8),   32'h3C);
      checkOutput("rst.qbar", 32'(qb8),  32'hC3);
      checkOutput("rst.cnt",  32'(cnt8), 32'd0);
      applyStimulus(0, 1, MODE_LOAD, 8'hA5, 0, 0);
      checkOutput("load.q",    32'(q8),   32'hA5);
      checkOutput("load.qbar", 32'(qb8),  32'h5A);
      checkOutput("load.cnt",  32'(cnt8), 32'd0);

      // Serial fill from the MSB end
      applyStimulus(0, 1, MODE_CLR, 8'h00, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(0, 1, MODE_SHR, 8'h00, 1, 0);
         checkOutput("fill.cnt",  32'(cnt8),  32'(i));
         checkOutput("fill.done", 32'(done8), (i == 8) ? 32'd1 : 32'd0);
         if (i == 1) begin
            checkOutput("w1.q",    32'(q1),    32'd1);
            checkOutput("w1.cnt",  32'(cnt1),  32'd1);
            checkOutput("w1.done", 32'(done1), 32'd1);
         end
      end
      checkOutput("fill.q", 32'(q8), 32'hFF);
      applyStimulus(0, 1, MODE_SHR, 8'h00, 1, 0);
      checkOutput("sat.cnt",  32'(cnt8),  32'd8);
      checkOutput("sat.done", 32'(done8), 32'd0);

      // Rotations
      applyStimulus(0, 1, MODE_LOAD, 8'h81, 0, 0);
      applyStimulus(0, 1, MODE_ROL, 8'h00, 0, 0);
      checkOutput("rol.q",   32'(q8),   32'h03);
      checkOutput("rol.sor", 32'(sor8), 32'd1);
      checkOutput("rol.sol", 32'(sol8), 32'd0);
      checkOutput("w1.rol",  32'(q1),   32'd1);
      applyStimulus(0, 1, MODE_ROR, 8'h00, 0, 0);
      checkOutput("ror1.q", 32'(q8), 32'h81);
      applyStimulus(0, 1, MODE_ROR, 8'h00, 0, 0);
      checkOutput("ror2.q",   32'(q8),   32'hC0);
      checkOutput("ror2.sor", 32'(sor8), 32'd0);
      checkOutput("ror2.sol", 32'(sol8), 32'd1);

      // Enable low blocks a pending load
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, MODE_LOAD, 8'h00, 0, 0);
         checkOutput("gate.q",    32'(q8),    32'hC0);
         checkOutput("gate.cnt",  32'(cnt8),  32'd3);
         checkOutput("gate.done", 32'(done8), 32'd0);
      end

      // Shift-left pattern
      applyStimulus(0, 1, MODE_SHL, 8'h00, 0, 1);
      checkOutput("shl1.q", 32'(q8), 32'h81);
      applyStimulus(0, 1, MODE_SHL, 8'h00, 0, 0);
      checkOutput("shl2.q", 32'(q8), 32'h02);
      applyStimulus(0, 1, MODE_SET, 8'h00, 0, 0);
      checkOutput("set.q", 32'(q8), 32'hFF);
      applyStimulus(0, 1, MODE_HOLD, 8'h55, 1, 1);
      checkOutput("hold.q", 32'(q8), 32'hFF);

      // Reset wins over a simultaneous SET in the middle of a shift run
      applyStimulus(0, 1, MODE_CLR, 8'h00, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, MODE_SHR, 8'h00, 0, 0);
      checkOutput("mid.cnt", 32'(cnt8), 32'd5);
      applyStimulus(1, 1, MODE_SET, 8'h00, 0, 0);
      checkOutput("midrst.q",    32'(q8),    32'h3C);
      checkOutput("midrst.cnt",  32'(cnt8),  32'd0);
      checkOutput("midrst.done", 32'(done8), 32'd0);
      applyStimulus(0, 1, MODE_HOLD, 8'h00, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
      $finish;
   end

endmodule
